// File: rtl/assoc_tlb_if.sv
// PTW handshake bundle between the TLB (master) and the page-table walker (slave).
// Request: valid/ready with vpn/asid; response: valid with ppn/level/pte/error.
interface assoc_tlb_if #(
   parameter int ASID_W = 16
);
   logic              ptw_req_valid_o;
   logic              ptw_req_ready_i;
   logic [26:0]       ptw_req_vpn_o;
   logic [ASID_W-1:0] ptw_req_asid_o;
   logic              ptw_resp_valid_i;
   logic [43:0]       ptw_resp_ppn_i;
   logic [1:0]        ptw_resp_level_i;
   logic [7:0]        ptw_resp_pte_i;
   logic              ptw_resp_error_i;

   modport master (
      output ptw_req_valid_o, ptw_req_vpn_o, ptw_req_asid_o,
      input  ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ppn_i,
      input  ptw_resp_level_i, ptw_resp_pte_i, ptw_resp_error_i
   );

   modport slave (
      input  ptw_req_valid_o, ptw_req_vpn_o, ptw_req_asid_o,
      output ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ppn_i,
      output ptw_resp_level_i, ptw_resp_pte_i, ptw_resp_error_i
   );
endinterface

// File: rtl/assoc_tlb.sv
// Fully-associative TLB: same-cycle lookup, tree-PLRU refill via PTW, flush.
// Ports: clk_i/rstn_i, lookup req_*/resp_*, ptw (assoc_tlb_if.master), flush_*.
// Macro ASSOC_TLB_SELECTIVE_FLUSH_EN enables VPN/ASID-filtered flush.
module assoc_tlb #(
   parameter int ENTRIES = 16,
   parameter int ASID_W  = 16
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              req_valid_i,
   input  logic [26:0]       req_vpn_i,
   input  logic [ASID_W-1:0] req_asid_i,
   input  logic              req_store_i,
   input  logic              req_fetch_i,
   input  logic              vm_en_i,
   input  logic [1:0]        priv_i,
   input  logic              sum_i,
   input  logic              mxr_i,
   output logic              ready_o,
   output logic              resp_hit_o,
   output logic              resp_miss_o,
   output logic [43:0]       resp_ppn_o,
   output logic              resp_xcpt_o,
   assoc_tlb_if.master       ptw,
   input  logic              flush_valid_i,
   input  logic [26:0]       flush_vpn_i,
   input  logic [ASID_W-1:0] flush_asid_i,
   input  logic              flush_use_vpn_i,
   input  logic              flush_use_asid_i,
   output logic              flush_done_o
);
   localparam int IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic              valid;
      logic              fault;
      logic [26:0]       vpn;
      logic [ASID_W-1:0] asid;
      logic [43:0]       ppn;
      logic [1:0]        lvl;
      logic              d;
      logic              g;
      logic              u;
      logic              x;
      logic              w;
      logic              r;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

   state_e            state_q, state_d;
   entry_t            ent_q [ENTRIES];
   entry_t            ent_d [ENTRIES];
   logic [ENTRIES-2:0] plru_q, plru_d;
   logic [26:0]       vpn_cap_q, vpn_cap_d;
   logic [ASID_W-1:0] asid_cap_q, asid_cap_d;
   logic [IDX_W-1:0]  vic_q, vic_d;
   logic              flush_done_q;

   logic [ENTRIES-1:0] hit_vec;
   logic [ENTRIES-1:0] flush_sel;
   logic [IDX_W-1:0]  hit_idx, inv_idx, plru_idx;
   logic              hit_any, inv_any;
   entry_t            hit_e;
   logic              bad_va, u_ok, t_ok, perm_ok, dirty_miss;
   logic              refill;

   // Superpages compare only the VPN bits above their page offset.
   function automatic logic vpn_match(logic [1:0] lvl,
                                      logic [26:0] a,
                                      logic [26:0] b);
      case (lvl)
         2'd1:    return a[26:9] == b[26:9];
         2'd2:    return a[26:18] == b[26:18];
         default: return a == b;
      endcase
   endfunction

   // Point every node on the path away from the touched leaf.
   function automatic logic [ENTRIES-2:0] plru_touch(logic [ENTRIES-2:0] t,
                                                     logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] node;
      logic             b;
      node = '0;
      for (int l = 0; l < IDX_W; l++) begin
         b       = idx[IDX_W-1-l];
         t[node] = ~b;
         node    = IDX_W'({node, 1'b1} + {{IDX_W{1'b0}}, b});
      end
      return t;
   endfunction

   function automatic logic [IDX_W-1:0] plru_victim(logic [ENTRIES-2:0] t);
      logic [IDX_W-1:0] node;
      logic [IDX_W-1:0] idx;
      logic             b;
      node = '0;
      idx  = '0;
      for (int l = 0; l < IDX_W; l++) begin
         b                = t[node];
         idx[IDX_W-1-l]   = b;
         node             = IDX_W'({node, 1'b1} + {{IDX_W{1'b0}}, b});
      end
      return idx;
   endfunction

   // Lookup
   always_comb begin
      hit_vec = '0;
      hit_idx = '0;
      hit_e   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit_vec[i] = ent_q[i].valid &&
                      vpn_match(ent_q[i].lvl, ent_q[i].vpn, req_vpn_i) &&
                      (ent_q[i].g || ent_q[i].asid == req_asid_i);
         if (hit_vec[i]) begin
            hit_idx = IDX_W'(i);
            hit_e   = entry_t'(hit_e | ent_q[i]);
         end
      end
   end

   assign hit_any = |hit_vec;
   assign bad_va  = req_vpn_i[26] ^ req_vpn_i[25];

   // SUM never grants fetch access to user pages from S-mode.
   assign u_ok = (priv_i == 2'd0) ? hit_e.u
                                  : (!hit_e.u || (sum_i && !req_fetch_i));
   assign t_ok = req_fetch_i ? hit_e.x
               : req_store_i ? hit_e.w
               : (hit_e.r || (hit_e.x && mxr_i));
   assign perm_ok = u_ok && t_ok;

   // First store to a clean writable page goes back to the PTW to set D.
   assign dirty_miss = req_store_i && hit_any && !hit_e.fault &&
                       perm_ok && !hit_e.d;

   always_comb begin
      if (!vm_en_i) begin
         resp_hit_o  = req_valid_i;
         resp_miss_o = 1'b0;
         resp_xcpt_o = 1'b0;
         resp_ppn_o  = {17'b0, req_vpn_i};
      end else begin
         resp_hit_o  = req_valid_i && hit_any && !dirty_miss;
         resp_miss_o = req_valid_i && !bad_va && (!hit_any || dirty_miss);
         resp_xcpt_o = req_valid_i &&
                       (bad_va || (hit_any && !dirty_miss &&
                                   (hit_e.fault || !perm_ok)));
         case (hit_e.lvl)
            2'd1:    resp_ppn_o = {hit_e.ppn[43:9], req_vpn_i[8:0]};
            2'd2:    resp_ppn_o = {hit_e.ppn[43:18], req_vpn_i[17:0]};
            default: resp_ppn_o = hit_e.ppn;
         endcase
      end
   end

   // Victim: lowest invalid entry, otherwise PLRU
   always_comb begin
      inv_any = 1'b0;
      inv_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) begin
            inv_any = 1'b1;
            inv_idx = IDX_W'(i);
         end
      end
   end

   assign plru_idx = plru_victim(plru_q);

`ifdef ASSOC_TLB_SELECTIVE_FLUSH_EN
   always_comb begin
      flush_sel = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         flush_sel[i] =
            (!flush_use_vpn_i ||
             vpn_match(ent_q[i].lvl, ent_q[i].vpn, flush_vpn_i)) &&
            (!flush_use_asid_i ||
             (!ent_q[i].g && ent_q[i].asid == flush_asid_i));
      end
   end
`else
   logic unused_flush;
   assign flush_sel    = '1;
   assign unused_flush = ^{flush_vpn_i, flush_asid_i,
                           flush_use_vpn_i, flush_use_asid_i};
`endif

   logic unused_pte;
   assign unused_pte = ^{ptw.ptw_resp_pte_i[6], ptw.ptw_resp_pte_i[0]};

   // Next state
   always_comb begin
      state_d    = state_q;
      ent_d      = ent_q;
      plru_d     = plru_q;
      vpn_cap_d  = vpn_cap_q;
      asid_cap_d = asid_cap_q;
      vic_d      = vic_q;
      refill     = 1'b0;

      if (resp_hit_o && vm_en_i)
         plru_d = plru_touch(plru_d, hit_idx);

      // Fault entries are one-shot; clean entries drop so the refill sets D.
      if (req_valid_i && vm_en_i && hit_any && (dirty_miss || hit_e.fault))
         ent_d[hit_idx].valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i && resp_miss_o) begin
               state_d    = S_REQ;
               vpn_cap_d  = req_vpn_i;
               asid_cap_d = req_asid_i;
               vic_d      = inv_any ? inv_idx : plru_idx;
            end
         end
         S_REQ: begin
            if (ptw.ptw_req_ready_i)
               state_d = flush_valid_i ? S_DROP : S_WAIT;
            else if (flush_valid_i)
               state_d = S_IDLE;
         end
         S_WAIT: begin
            if (flush_valid_i) begin
               state_d = ptw.ptw_resp_valid_i ? S_IDLE : S_DROP;
            end else if (ptw.ptw_resp_valid_i) begin
               refill  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DROP: begin
            if (ptw.ptw_resp_valid_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (refill) begin
         ent_d[vic_q].valid = 1'b1;
         ent_d[vic_q].fault = ptw.ptw_resp_error_i;
         ent_d[vic_q].vpn   = vpn_cap_q;
         ent_d[vic_q].asid  = asid_cap_q;
         ent_d[vic_q].ppn   = ptw.ptw_resp_ppn_i;
         ent_d[vic_q].lvl   = ptw.ptw_resp_level_i;
         ent_d[vic_q].d     = ptw.ptw_resp_pte_i[7];
         ent_d[vic_q].g     = ptw.ptw_resp_pte_i[5];
         ent_d[vic_q].u     = ptw.ptw_resp_pte_i[4];
         ent_d[vic_q].x     = ptw.ptw_resp_pte_i[3];
         ent_d[vic_q].w     = ptw.ptw_resp_pte_i[2];
         ent_d[vic_q].r     = ptw.ptw_resp_pte_i[1];
         plru_d = plru_touch(plru_d, vic_q);
      end

      // Flush is applied last so it wins over any write this cycle.
      if (flush_valid_i) begin
         for (int i = 0; i < ENTRIES; i++)
            if (flush_sel[i])
               ent_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= S_IDLE;
         plru_q       <= '0;
         vpn_cap_q    <= '0;
         asid_cap_q   <= '0;
         vic_q        <= '0;
         flush_done_q <= 1'b0;
         for (int i = 0; i < ENTRIES; i++)
            ent_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         plru_q       <= plru_d;
         vpn_cap_q    <= vpn_cap_d;
         asid_cap_q   <= asid_cap_d;
         vic_q        <= vic_d;
         flush_done_q <= flush_valid_i;
         ent_q        <= ent_d;
      end
   end

   assign ready_o             = (state_q == S_IDLE);
   assign flush_done_o        = flush_done_q;
   assign ptw.ptw_req_valid_o = (state_q == S_REQ);
   assign ptw.ptw_req_vpn_o   = vpn_cap_q;
   assign ptw.ptw_req_asid_o  = asid_cap_q;
endmodule

// File: tb/tb_assoc_tlb.sv
// Directed self-checking bench for assoc_tlb (ENTRIES=4).
// Covers lookup, refill, superpages, permissions, dirty/fault, flush, PLRU.
module tb_assoc_tlb;
   localparam int ENTRIES = 4;
   localparam int ASID_W  = 16;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              req_valid_i;
   logic [26:0]       req_vpn_i;
   logic [ASID_W-1:0] req_asid_i;
   logic              req_store_i;
   logic              req_fetch_i;
   logic              vm_en_i;
   logic [1:0]        priv_i;
   logic              sum_i;
   logic              mxr_i;
   logic              ready_o;
   logic              resp_hit_o;
   logic              resp_miss_o;
   logic [43:0]       resp_ppn_o;
   logic              resp_xcpt_o;
   logic              flush_valid_i;
   logic [26:0]       flush_vpn_i;
   logic [ASID_W-1:0] flush_asid_i;
   logic              flush_use_vpn_i;
   logic              flush_use_asid_i;
   logic              flush_done_o;

   int n_chk = 0;
   int n_err = 0;

   assoc_tlb_if #(.ASID_W(ASID_W)) ptw_if ();

   assoc_tlb #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .req_valid_i      (req_valid_i),
      .req_vpn_i        (req_vpn_i),
      .req_asid_i       (req_asid_i),
      .req_store_i      (req_store_i),
      .req_fetch_i      (req_fetch_i),
      .vm_en_i          (vm_en_i),
      .priv_i           (priv_i),
      .sum_i            (sum_i),
      .mxr_i            (mxr_i),
      .ready_o          (ready_o),
      .resp_hit_o       (resp_hit_o),
      .resp_miss_o      (resp_miss_o),
      .resp_ppn_o       (resp_ppn_o),
      .resp_xcpt_o      (resp_xcpt_o),
      .ptw              (ptw_if),
      .flush_valid_i    (flush_valid_i),
      .flush_vpn_i      (flush_vpn_i),
      .flush_asid_i     (flush_asid_i),
      .flush_use_vpn_i  (flush_use_vpn_i),
      .flush_use_asid_i (flush_use_asid_i),
      .flush_done_o     (flush_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic look(input logic [26:0] vpn, input logic [15:0] asid,
                       input logic st, input logic fe);
      req_vpn_i   = vpn;
      req_asid_i  = asid;
      req_store_i = st;
      req_fetch_i = fe;
      req_valid_i = 1'b1;
      #1;
   endtask

   task automatic idle();
      req_valid_i = 1'b0;
      req_store_i = 1'b0;
      req_fetch_i = 1'b0;
      #1;
   endtask

   task automatic ptw_done(input logic [43:0] ppn, input logic [1:0] lvl,
                           input logic [7:0] pte, input logic err);
      ptw_if.ptw_req_ready_i = 1'b1;
      step();
      ptw_if.ptw_req_ready_i  = 1'b0;
      ptw_if.ptw_resp_ppn_i   = ppn;
      ptw_if.ptw_resp_level_i = lvl;
      ptw_if.ptw_resp_pte_i   = pte;
      ptw_if.ptw_resp_error_i = err;
      ptw_if.ptw_resp_valid_i = 1'b1;
      step();
      ptw_if.ptw_resp_valid_i = 1'b0;
   endtask

   task automatic refill(input logic [26:0] vpn, input logic [15:0] asid,
                         input logic [43:0] ppn, input logic [1:0] lvl,
                         input logic [7:0] pte, input logic err);
      int n;
      look(vpn, asid, 1'b0, 1'b0);
      step();
      idle();
      n = 0;
      while (!ptw_if.ptw_req_valid_o && n < 10) begin
         step();
         n++;
      end
      chk("ptw_req_valid", ptw_if.ptw_req_valid_o, 1);
      chk("ptw_req_vpn", ptw_if.ptw_req_vpn_o, vpn);
      ptw_done(ppn, lvl, pte, err);
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      #12;
      rstn_i = 1'b1;
      step();
   endtask

   initial begin
      rstn_i                  = 1'b0;
      req_valid_i             = 1'b0;
      req_vpn_i               = '0;
      req_asid_i              = '0;
      req_store_i             = 1'b0;
      req_fetch_i             = 1'b0;
      vm_en_i                 = 1'b1;
      priv_i                  = 2'd1;
      sum_i                   = 1'b0;
      mxr_i                   = 1'b0;
      flush_valid_i           = 1'b0;
      flush_vpn_i             = '0;
      flush_asid_i            = '0;
      flush_use_vpn_i         = 1'b0;
      flush_use_asid_i        = 1'b0;
      ptw_if.ptw_req_ready_i  = 1'b0;
      ptw_if.ptw_resp_valid_i = 1'b0;
      ptw_if.ptw_resp_ppn_i   = '0;
      ptw_if.ptw_resp_level_i = '0;
      ptw_if.ptw_resp_pte_i   = '0;
      ptw_if.ptw_resp_error_i = 1'b0;

      // Reset state
      #7;
      chk("rst_ready", ready_o, 1);
      chk("rst_hit", resp_hit_o, 0);
      chk("rst_miss", resp_miss_o, 0);
      chk("rst_ptw_valid", ptw_if.ptw_req_valid_o, 0);
      chk("rst_flush_done", flush_done_o, 0);
      rstn_i = 1'b1;
      step();

      // 4K miss then refill, then hit
      look(27'h12345, 16'd3, 1'b0, 1'b0);
      chk("4k_miss", resp_miss_o, 1);
      chk("4k_nohit", resp_hit_o, 0);
      idle();
      refill(27'h12345, 16'd3, 44'h80000, 2'd0, 8'hCF, 1'b0);
      chk("4k_ready", ready_o, 1);
      look(27'h12345, 16'd3, 1'b0, 1'b0);
      chk("4k_hit", resp_hit_o, 1);
      chk("4k_ppn", resp_ppn_o, 44'h80000);
      chk("4k_xcpt", resp_xcpt_o, 0);
      idle();
      look(27'h12345, 16'd4, 1'b0, 1'b0);
      chk("asid_mismatch_miss", resp_miss_o, 1);
      idle();

      // 2M superpage
      refill(27'h00600, 16'd3, 44'h80200, 2'd1, 8'hCF, 1'b0);
      look(27'h007AB, 16'd3, 1'b0, 1'b0);
      chk("2m_hit", resp_hit_o, 1);
      chk("2m_ppn", resp_ppn_o, 44'h803AB);
      idle();

      // Permissions / bad VA / bypass
      priv_i = 2'd0;
      look(27'h12345, 16'd3, 1'b0, 1'b0);
      chk("umode_xcpt", resp_xcpt_o, 1);
      idle();
      priv_i = 2'd1;
      look(27'h12345, 16'd3, 1'b0, 1'b1);
      chk("fetch_ok", resp_xcpt_o, 0);
      idle();
      look(27'h4000000, 16'd3, 1'b0, 1'b0);
      chk("badva_xcpt", resp_xcpt_o, 1);
      chk("badva_nomiss", resp_miss_o, 0);
      idle();
      vm_en_i = 1'b0;
      look(27'h1234567, 16'd3, 1'b1, 1'b0);
      chk("bypass_hit", resp_hit_o, 1);
      chk("bypass_miss", resp_miss_o, 0);
      chk("bypass_ppn", resp_ppn_o, 44'h1234567);
      chk("bypass_xcpt", resp_xcpt_o, 0);
      idle();
      vm_en_i = 1'b1;

      // Store to clean page
      refill(27'h00100, 16'd3, 44'h90000, 2'd0, 8'h4F, 1'b0);
      look(27'h00100, 16'd3, 1'b1, 1'b0);
      chk("dirty_miss", resp_miss_o, 1);
      chk("dirty_nohit", resp_hit_o, 0);
      step();
      idle();
      chk("dirty_ptw_valid", ptw_if.ptw_req_valid_o, 1);
      chk("dirty_ptw_vpn", ptw_if.ptw_req_vpn_o, 27'h00100);
      chk("dirty_ptw_asid", ptw_if.ptw_req_asid_o, 16'd3);
      look(27'h00100, 16'd3, 1'b0, 1'b0);
      chk("dirty_cleared", resp_miss_o, 1);
      idle();
      ptw_done(44'h90000, 2'd0, 8'hCF, 1'b0);
      look(27'h00100, 16'd3, 1'b1, 1'b0);
      chk("dirty_store_hit", resp_hit_o, 1);
      chk("dirty_store_nomiss", resp_miss_o, 0);
      idle();

      // Fault entry: hit with xcpt once, then gone
      refill(27'h00200, 16'd3, 44'h0, 2'd0, 8'h00, 1'b1);
      look(27'h00200, 16'd3, 1'b0, 1'b0);
      chk("fault_hit", resp_hit_o, 1);
      chk("fault_xcpt", resp_xcpt_o, 1);
      step();
      chk("fault_cleared", resp_miss_o, 1);
      idle();

      // Flush during WAIT drops the response
      look(27'h00300, 16'd3, 1'b0, 1'b0);
      step();
      idle();
      ptw_if.ptw_req_ready_i = 1'b1;
      step();
      ptw_if.ptw_req_ready_i = 1'b0;
      flush_valid_i = 1'b1;
      step();
      flush_valid_i = 1'b0;
      #1;
      chk("flush_done", flush_done_o, 1);
      chk("drop_not_ready", ready_o, 0);
      ptw_if.ptw_resp_ppn_i   = 44'hAAAAA;
      ptw_if.ptw_resp_level_i = 2'd0;
      ptw_if.ptw_resp_pte_i   = 8'hCF;
      ptw_if.ptw_resp_error_i = 1'b0;
      ptw_if.ptw_resp_valid_i = 1'b1;
      step();
      ptw_if.ptw_resp_valid_i = 1'b0;
      chk("drop_idle", ready_o, 1);
      chk("flush_done_pulse", flush_done_o, 0);
      look(27'h00300, 16'd3, 1'b0, 1'b0);
      chk("drop_miss_again", resp_miss_o, 1);
      idle();
      look(27'h12345, 16'd3, 1'b0, 1'b0);
      chk("flush_all_cleared", resp_miss_o, 1);
      idle();

      // Reset mid-miss; stale response ignored
      look(27'h00400, 16'd3, 1'b0, 1'b0);
      step();
      idle();
      ptw_if.ptw_req_ready_i = 1'b1;
      step();
      ptw_if.ptw_req_ready_i = 1'b0;
      do_reset();
      ptw_if.ptw_resp_valid_i = 1'b1;
      step();
      ptw_if.ptw_resp_valid_i = 1'b0;
      chk("rst_mid_ready", ready_o, 1);
      chk("rst_mid_ptw_valid", ptw_if.ptw_req_valid_o, 0);
      look(27'h00400, 16'd3, 1'b0, 1'b0);
      chk("rst_mid_miss", resp_miss_o, 1);
      idle();

      // PLRU victim after filling 4 entries
      for (int i = 0; i < 5; i++)
         refill(27'h01000 + 27'(i), 16'd3, 44'h100 + 44'(i),
                2'd0, 8'hCF, 1'b0);
      look(27'h01000, 16'd3, 1'b0, 1'b0);
      chk("plru_evicted", resp_miss_o, 1);
      idle();
      look(27'h01001, 16'd3, 1'b0, 1'b0);
      chk("plru_kept", resp_hit_o, 1);
      chk("plru_kept_ppn", resp_ppn_o, 44'h101);
      idle();
      look(27'h01004, 16'd3, 1'b0, 1'b0);
      chk("plru_new_hit", resp_hit_o, 1);
      chk("plru_new_ppn", resp_ppn_o, 44'h104);
      idle();

      // ASID-3 flush with G entry and other ASID
      do_reset();
      refill(27'h02000, 16'd3, 44'h200, 2'd0, 8'hCF, 1'b0);
      refill(27'h02001, 16'd3, 44'h201, 2'd0, 8'hEF, 1'b0);
      refill(27'h02002, 16'd5, 44'h202, 2'd0, 8'hCF, 1'b0);
      flush_use_asid_i = 1'b1;
      flush_asid_i     = 16'd3;
      flush_valid_i    = 1'b1;
      step();
      flush_valid_i    = 1'b0;
      flush_use_asid_i = 1'b0;
      look(27'h02000, 16'd3, 1'b0, 1'b0);
      chk("sel_asid3_gone", resp_miss_o, 1);
      idle();
`ifdef ASSOC_TLB_SELECTIVE_FLUSH_EN
      look(27'h02001, 16'd3, 1'b0, 1'b0);
      chk("sel_global_kept", resp_hit_o, 1);
      idle();
      look(27'h02002, 16'd5, 1'b0, 1'b0);
      chk("sel_asid5_kept", resp_hit_o, 1);
      idle();
`else
      look(27'h02001, 16'd3, 1'b0, 1'b0);
      chk("all_global_gone", resp_miss_o, 1);
      idle();
      look(27'h02002, 16'd5, 1'b0, 1'b0);
      chk("all_asid5_gone", resp_miss_o, 1);
      idle();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
